// File: rtl/cp0_defs.sv
// Shared CP0 constants: register numbers, excepttype encodings, ExcCodes and field positions.
// decode_exc maps an M-stage excepttype onto the ExcCode it records.
package cp0_defs;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam int unsigned STATUS_IE      = 0;
    localparam int unsigned STATUS_EXL     = 1;
    localparam int unsigned STATUS_IM_LO   = 8;
    localparam int unsigned STATUS_IM_HI   = 15;
    localparam int unsigned STATUS_BEV     = 22;
    localparam int unsigned CAUSE_EXC_LO   = 2;
    localparam int unsigned CAUSE_EXC_HI   = 6;
    localparam int unsigned CAUSE_IP_LO    = 8;
    localparam int unsigned CAUSE_IP_HI    = 15;
    localparam int unsigned CAUSE_IP_SW_HI = 9;
    localparam int unsigned CAUSE_IP_HW_LO = 10;
    localparam int unsigned CAUSE_BD       = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

    typedef struct packed {
        logic       valid;
        logic       bad_addr;
        logic [4:0] code;
    } exc_info_t;

    function automatic exc_info_t decode_exc(input logic [31:0] t);
        exc_info_t info;
        info = '{valid: 1'b1, bad_addr: 1'b0, code: EXCCODE_INT};
        case (t)
            EXC_INT:  info.code = EXCCODE_INT;
            EXC_ADEL: begin info.code = EXCCODE_ADEL; info.bad_addr = 1'b1; end
            EXC_ADES: begin info.code = EXCCODE_ADES; info.bad_addr = 1'b1; end
            EXC_SYS:  info.code = EXCCODE_SYS;
            EXC_BP:   info.code = EXCCODE_BP;
            EXC_RI:   info.code = EXCCODE_RI;
            EXC_OV:   info.code = EXCCODE_OV;
            default:  info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every clock or every other clock, and the interrupt
// latches on a nonzero Count==Compare match until Compare is rewritten.
module cp0_timer
    import cp0_defs::*;
#(
    parameter bit COUNT_HALF_RATE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tog_q, tog_d;
    logic        tint_q, tint_d;
    logic        inc;

    always_comb begin
        inc       = COUNT_HALF_RATE ? tog_q : 1'b1;
        tog_d     = COUNT_HALF_RATE ? ~tog_q : 1'b0;
        count_d   = count_we ? wdata : count_q + {31'b0, inc};
        compare_d = compare_we ? wdata : compare_q;
        tint_d    = tint_q | ((count_q == compare_q) && (compare_q != 32'h0));
        // Rewriting Compare acknowledges the interrupt, even against a match this cycle.
        if (compare_we) begin
            tint_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            tog_q     <= 1'b0;
            tint_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tog_q     <= tog_d;
            tint_q    <= tint_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status/Cause/EPC/BadVAddr updated by mtc0, exceptions and eret,
// plus the Count/Compare timer and an mfc0 read port.
module cp0_reg
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID            = 32'h004c_0102,
    parameter logic [31:0] CONFIG_VAL      = 32'h0000_0000,
    parameter bit          COUNT_HALF_RATE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic        wr;
    exc_info_t   info;

    // An instruction that raises anything is flushed, so its mtc0 never lands.
    assign wr   = we_i && (excepttype_i == 32'h0);
    assign info = decode_exc(excepttype_i);

    cp0_timer #(
        .COUNT_HALF_RATE(COUNT_HALF_RATE)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (wr && (waddr_i == REG_COUNT)),
        .compare_we (wr && (waddr_i == REG_COMPARE)),
        .wdata      (data_i),
        .count_o    (count_o),
        .compare_o  (compare_o),
        .timer_int_o(timer_int_o)
    );

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        badv_d   = badv_q;

        cause_d[CAUSE_IP_HI:CAUSE_IP_HW_LO] = {int_i[5] | timer_int_o, int_i[4:0]};

        if (wr) begin
            case (waddr_i)
                REG_STATUS: status_d = STATUS_RESET | (data_i & STATUS_WMASK);
                REG_CAUSE:  cause_d[CAUSE_IP_SW_HI:CAUSE_IP_LO] = data_i[9:8];
                REG_EPC:    epc_d = data_i;
                default:    ;
            endcase
        end

        if (info.valid) begin
            // Nested exceptions keep the original return point.
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                      : current_inst_addr_i;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            status_d[STATUS_EXL]                = 1'b1;
            cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = info.code;
            if (info.bad_addr) begin
                badv_d = bad_addr_i;
            end
        end else if (excepttype_i == EXC_ERET) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q <= STATUS_RESET;
            cause_q  <= 32'h0;
            epc_q    <= 32'h0;
            badv_q   <= 32'h0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
        end
    end

    always_comb begin
        data_o = 32'h0;
        case (raddr_i)
            REG_BADVADDR: data_o = badv_q;
            REG_COUNT:    data_o = count_o;
            REG_COMPARE:  data_o = compare_o;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = cause_q;
            REG_EPC:      data_o = epc_q;
            REG_PRID:     data_o = PRID;
            REG_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = 32'h0;
        endcase
    end

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badv_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: a register-level model checked on every negedge,
// plus literal expectations for the key scenarios.
module tb_cp0_reg;

    logic        clk;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int_o;

    cp0_reg dut (
        .clk                (clk),
        .resetn             (resetn),
        .we_i               (we_i),
        .waddr_i            (waddr_i),
        .raddr_i            (raddr_i),
        .data_i             (data_i),
        .int_i              (int_i),
        .excepttype_i       (excepttype_i),
        .current_inst_addr_i(current_inst_addr_i),
        .is_in_delayslot_i  (is_in_delayslot_i),
        .bad_addr_i         (bad_addr_i),
        .data_o             (data_o),
        .status_o           (status_o),
        .cause_o            (cause_o),
        .epc_o              (epc_o),
        .count_o            (count_o),
        .compare_o          (compare_o),
        .badvaddr_o         (badvaddr_o),
        .timer_int_o        (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_tint, m_tog;

    logic [4:0] rd_list [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd3};
    int rd_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h004c_0102;
            default: return 32'h0;
        endcase
    endfunction

    // Applies one clock edge of architectural CP0 behaviour to the model state.
    task automatic model_edge();
        logic [31:0] ns, nc, ne, nb, ncnt, ncmp;
        logic        nti;
        logic [4:0]  code;
        bit          valid;
        if (!resetn) begin
            m_status = 32'h0040_0000;
            m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
            m_tint = 0; m_tog = 0;
            return;
        end
        ns = m_status; nc = m_cause; ne = m_epc; nb = m_badv;
        nc[15:10] = {int_i[5] | m_tint, int_i[4:0]};
        ncnt = m_count + (m_tog ? 32'd1 : 32'd0);
        ncmp = m_compare;
        nti  = m_tint || (m_count == m_compare && m_compare != 0);
        if (we_i && excepttype_i == 0) begin
            case (waddr_i)
                5'd9:  ncnt = data_i;
                5'd11: begin ncmp = data_i; nti = 1'b0; end
                5'd12: ns = 32'h0040_0000 | (data_i & 32'h0000_ff03);
                5'd13: nc[9:8] = data_i[9:8];
                5'd14: ne = data_i;
                default: ;
            endcase
        end
        valid = 1'b1;
        code  = 5'd0;
        case (excepttype_i)
            32'h1: code = 5'd0;
            32'h4: code = 5'd4;
            32'h5: code = 5'd5;
            32'h8: code = 5'd8;
            32'h9: code = 5'd9;
            32'ha: code = 5'd10;
            32'hc: code = 5'd12;
            default: valid = 1'b0;
        endcase
        if (valid) begin
            if (m_status[1] == 1'b0) begin
                ne = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
                nc[31] = is_in_delayslot_i;
            end
            ns[1] = 1'b1;
            nc[6:2] = code;
            if (excepttype_i == 32'h4 || excepttype_i == 32'h5) nb = bad_addr_i;
        end else if (excepttype_i == 32'he) begin
            ns[1] = 1'b0;
        end
        m_status = ns; m_cause = nc; m_epc = ne; m_badv = nb;
        m_count = ncnt; m_compare = ncmp; m_tint = nti;
        m_tog = ~m_tog;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        raddr_i = rd_list[rd_idx % 10];
        rd_idx++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("status", status_o, m_status);
            check("cause", cause_o, m_cause);
            check("epc", epc_o, m_epc);
            check("badvaddr", badvaddr_o, m_badv);
            check("count", count_o, m_count);
            check("compare", compare_o, m_compare);
            check("timer_int", {31'b0, timer_int_o}, {31'b0, m_tint});
            check("data_o", data_o, m_read(raddr_i));
        end
    end

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
        excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
        tick();
        excepttype_i = 32'h0; is_in_delayslot_i = 1'b0;
    endtask

    initial begin
        bit found;
        resetn = 1'b0; we_i = 1'b0; waddr_i = 0; raddr_i = 0; data_i = 0; int_i = 0;
        excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0; bad_addr_i = 0;
        tick();
        tick();
        chk_en = 1'b1;
        resetn = 1'b1;

        // Idle after reset at half rate.
        repeat (10) tick();
        check("lit_status_reset", status_o, 32'h0040_0000);
        check("lit_count_10", count_o, 32'd5);
        check("lit_tint_reset", {31'b0, timer_int_o}, 32'd0);
        raddr_i = 5'd15;
        #1;
        check("lit_prid", data_o, 32'h004c_0102);

        // Timer match and Compare-write acknowledge.
        mtc0(5'd11, 32'd8);
        mtc0(5'd9, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (timer_int_o) found = 1'b1;
        end
        check("lit_timer_rise", {31'b0, found}, 32'd1);
        check("lit_count_at_rise", count_o, 32'd8);
        tick();
        check("lit_cause15", {31'b0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        check("lit_tint_clear", {31'b0, timer_int_o}, 32'd0);

        // Syscall, not in delay slot.
        exc(32'h8, 32'hbfc0_0100, 1'b0, 32'h0);
        check("lit_epc_sys", epc_o, 32'hbfc0_0100);
        check("lit_exccode_sys", {27'b0, cause_o[6:2]}, 32'd8);
        check("lit_exl_sys", {31'b0, status_o[1]}, 32'd1);
        check("lit_bd_sys", {31'b0, cause_o[31]}, 32'd0);
        exc(32'he, 32'h0, 1'b0, 32'h0);
        check("lit_eret1", {31'b0, status_o[1]}, 32'd0);

        // AdEL in a delay slot, then a nested AdES.
        exc(32'h4, 32'hbfc0_0204, 1'b1, 32'hbfc0_0203);
        check("lit_epc_adel", epc_o, 32'hbfc0_0200);
        check("lit_bd_adel", {31'b0, cause_o[31]}, 32'd1);
        check("lit_badv_adel", badvaddr_o, 32'hbfc0_0203);
        check("lit_exccode_adel", {27'b0, cause_o[6:2]}, 32'd4);
        exc(32'h5, 32'h0000_0400, 1'b0, 32'h0000_0401);
        check("lit_epc_nested", epc_o, 32'hbfc0_0200);
        check("lit_exccode_nested", {27'b0, cause_o[6:2]}, 32'd5);
        check("lit_badv_nested", badvaddr_o, 32'h0000_0401);

        // mtc0 EPC discarded by a same-cycle overflow.
        exc(32'he, 32'h0, 1'b0, 32'h0);
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234;
        exc(32'hc, 32'h8000_0010, 1'b0, 32'h0);
        we_i = 1'b0;
        check("lit_epc_ov", epc_o, 32'h8000_0010);
        check("lit_exccode_ov", {27'b0, cause_o[6:2]}, 32'd12);
        exc(32'he, 32'h0, 1'b0, 32'h0);
        check("lit_eret2", {31'b0, status_o[1]}, 32'd0);

        // Unknown excepttype: no change, write still discarded.
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h5555;
        exc(32'h3, 32'h0000_0100, 1'b1, 32'h0);
        we_i = 1'b0;
        check("lit_epc_unknown", epc_o, 32'h8000_0010);

        // Hardware interrupt lines and Cause write mask.
        int_i = 6'b000001;
        tick();
        check("lit_cause10", {31'b0, cause_o[10]}, 32'd1);
        mtc0(5'd13, 32'hffff_ffff);
        check("lit_cause_ip_sw", {30'b0, cause_o[9:8]}, 32'd3);
        check("lit_cause_hi_zero", {17'b0, cause_o[30:16]}, 32'd0);
        int_i = 6'b100000;
        tick();
        tick();

        // Status mask, Count wrap, same-cycle match and clear.
        mtc0(5'd12, 32'hffff_ffff);
        check("lit_status_mask", status_o, 32'h0040_ff03);
        mtc0(5'd9, 32'hffff_fffe);
        repeat (6) tick();
        mtc0(5'd11, 32'd3);
        repeat (12) tick();
        mtc0(5'd11, 32'd3);
        repeat (4) tick();

        // Reset mid-operation with a write pending.
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hdead_beef;
        excepttype_i = 32'h8; int_i = 6'h3f;
        resetn = 1'b0;
        tick();
        check("lit_status_midreset", status_o, 32'h0040_0000);
        check("lit_epc_midreset", epc_o, 32'h0);
        resetn = 1'b1; we_i = 1'b0; excepttype_i = 0; int_i = 0;
        repeat (4) tick();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the five-stage MIPS pipeline, directly downstream of the M-stage exception classifier.
- Consumes the encoded exception type, faulting PC, delay-slot flag and bad address. Updates Status, Cause, EPC and BadVAddr on exceptions and eret.
- Services mtc0 writes and mfc0 reads.
- Hosts the Count/Compare timer, and feeds Status/Cause back to the classifier for interrupt detection.

Parameters:
- PRID, 32'h004c_0102, read-only value of PRId (reg 15).
- CONFIG_VAL, 32'h0000_0000, read-only value of Config (reg 16).
- COUNT_HALF_RATE, 1, when 1 Count increments every second clock; when 0, every clock.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  synchronous active-low reset.
- we_i  in  1  mtc0 write enable.
- waddr_i  in  5  mtc0 target register number.
- raddr_i  in  5  mfc0 source register number.
- data_i  in  32  mtc0 write data.
- int_i  in  6  external hardware interrupts, level-sensitive.
- excepttype_i  in  32  M-stage exception code; 0 means none.
- current_inst_addr_i  in  32  PC of the M-stage instruction.
- is_in_delayslot_i  in  1  M-stage instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting virtual address for AdEL/AdES.
- data_o  out  32  mfc0 read data, combinational from raddr_i.
- status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  out  32 each  current register values.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
Reset (resetn==0 at a clock edge):
- Status=32'h0040_0000 (BEV=1).
- Cause, EPC, Count, Compare and BadVAddr = 0.
- timer_int_o=0, count toggle=0.
- Reset applies mid-operation regardless of other inputs.

Register map:
- 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
- Other addresses read 0 and ignore writes.

mtc0 writable fields:
- Status: IM[15:8], EXL[1], IE[0]; BEV[22] stays 1; other bits read 0.
- Cause: IP[9:8] only.
- EPC, Count, Compare: full 32 bits.
- BadVAddr, PRId, Config: read-only.
- Writes take effect at the edge; data_o shows the old value in the same cycle (no bypass; the hazard unit handles it).

Cause hardware bits:
- Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]} every cycle.

Timer:
- COUNT_HALF_RATE=1: a toggle flips each cycle, and Count += 1 when toggle==1. Count wraps 32'hFFFF_FFFF -> 0.
- timer_int_o sets when Count==Compare and Compare!=0. It stays set until an mtc0 to Compare, which clears it.
- A Compare write in the same cycle as a match: the clear wins.
- An mtc0 to Count loads data_i and suppresses that cycle's increment; the toggle is unaffected.

Exception entry (excepttype_i in {1,4,5,8,9,a,c}):
- If Status.EXL==0: EPC <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i, and Cause.BD[31] <= is_in_delayslot_i.
- If Status.EXL==1: EPC and BD are unchanged.
- Status.EXL <= 1.
- Cause.ExcCode[6:2] by excepttype_i: 1->0 (Int), 4->4 (AdEL), 5->5 (AdES), 8->8 (Sys), 9->9 (Bp), a->10 (RI), c->12 (Ov).
- For 4 or 5 only: BadVAddr <= bad_addr_i.

Eret (excepttype_i==32'he):
- Status.EXL <= 0; nothing else changes.

Simultaneous events:
- When excepttype_i!=0, the mtc0 write in that cycle is discarded, because that instruction is flushed.
- Timer and Cause.IP hardware updates still occur.
- Unknown nonzero excepttype_i values: no state change.

Decomposition:
- Package cp0_defs holds:
  - register-number constants;
  - excepttype encodings (EXC_INT=1, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=a, EXC_OV=c, EXC_ERET=e);
  - ExcCode values;
  - Status/Cause bit positions (IE 0, EXL 1, IM 15:8, BEV 22, ExcCode 6:2, IP 15:8, BD 31).
- One sub-module, cp0_timer: Count, toggle, Compare, timer_int. Inputs are write strobes and data; outputs are count_o, compare_o and timer_int_o.

Test Plan:
1. Release reset, idle 10 cycles -> status_o=32'h0040_0000, count_o=5 (half rate), timer_int_o=0, data_o(raddr=15)=PRID.
2. mtc0 Compare=8 then Count=0 -> timer_int_o rises the cycle after Count reaches 8 and cause_o[15]=1. mtc0 Compare=100 -> timer_int_o=0 next cycle.
3. excepttype_i=8, pc=32'hbfc0_0100, delayslot=0 -> epc_o=32'hbfc0_0100, cause_o[6:2]=8, status_o[1]=1, BD=0.
4. excepttype_i=4, delayslot=1, pc=32'hbfc0_0204, bad_addr_i=32'hbfc0_0203 -> epc_o=32'hbfc0_0200, BD=1, badvaddr_o=32'hbfc0_0203, ExcCode=4. A second exception while EXL=1 -> EPC unchanged, ExcCode updated.
5. mtc0 EPC=32'h1234 with excepttype_i=c in the same cycle -> EPC set from the PC, not 32'h1234. Then excepttype_i=e -> status_o[1]=0.
6. int_i=6'b000001 held -> cause_o[10]=1 next cycle. mtc0 Cause=32'hFFFF_FFFF -> only cause_o[9:8] become 1.
